// File: rtl/wire_pack_5x3_to_4x4.sv
// Packs five 3-bit fields plus a constant marker bit into four 4-bit nibbles.
// Define WIRE_PACK_REG_OUT_EN to add the registered copy, valid flag and capture counter.
module wire_pack_5x3_to_4x4 (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] in0,
  input  logic [2:0] in1,
  input  logic [2:0] in2,
  input  logic [2:0] in3,
  input  logic [2:0] in4,
  input  logic       in_val,
  output logic [3:0] out0,
  output logic [3:0] out1,
  output logic [3:0] out2,
  output logic [3:0] out3,
  output logic [3:0] reg_out0,
  output logic [3:0] reg_out1,
  output logic [3:0] reg_out2,
  output logic [3:0] reg_out3,
  output logic       reg_val,
  output logic [7:0] cap_cnt
);

  logic [15:0] word;

  // Bit 15 is a constant marker so downstream can tell a packed word from idle zeros.
  assign word = {1'b1, in4, in3, in2, in1, in0};

  assign out0 = word[3:0];
  assign out1 = word[7:4];
  assign out2 = word[11:8];
  assign out3 = word[15:12];

`ifdef WIRE_PACK_REG_OUT_EN

  logic        rst_sync_q;
  logic        capture;
  logic [15:0] word_q, word_d;
  logic        val_q, val_d;
  logic [7:0]  cnt_q, cnt_d;

  // NOTE: reset asserts asynchronously but releases on a clock edge, so the
  // edge on which reset rises never captures; the first capture is one edge later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync_q <= 1'b0;
    else        rst_sync_q <= 1'b1;
  end

  assign capture = in_val & rst_sync_q;

  // NOTE: every variable assigned here gets a default first, so no latch is inferred.
  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    val_d  = 1'b0;
    if (capture) begin
      word_d = word;
      cnt_d  = cnt_q + 8'd1;
      val_d  = 1'b1;
    end
  end

  // NOTE: state is updated with non-blocking assignments so all flops sample together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word_q <= 16'h0000;
      val_q  <= 1'b0;
      cnt_q  <= 8'h00;
    end else begin
      word_q <= word_d;
      val_q  <= val_d;
      cnt_q  <= cnt_d;
    end
  end

  assign reg_out0 = word_q[3:0];
  assign reg_out1 = word_q[7:4];
  assign reg_out2 = word_q[11:8];
  assign reg_out3 = word_q[15:12];
  assign reg_val  = val_q;
  assign cap_cnt  = cnt_q;

`else

  logic unused_ctrl;

  // Clock, reset and in_val have no function when the registered path is absent.
  assign unused_ctrl = &{1'b0, clk, reset, in_val};

  assign reg_out0 = 4'h0;
  assign reg_out1 = 4'h0;
  assign reg_out2 = 4'h0;
  assign reg_out3 = 4'h0;
  assign reg_val  = 1'b0;
  assign cap_cnt  = 8'h00;

`endif

endmodule

// File: tb/tb_wire_pack_5x3_to_4x4.sv
// Scoreboard bench for wire_pack_5x3_to_4x4: the driver queues one expectation per
// cycle, the monitor pops and compares after each rising edge.
module tb_wire_pack_5x3_to_4x4;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] in0, in1, in2, in3, in4;
  logic       in_val;
  logic [3:0] out0, out1, out2, out3;
  logic [3:0] reg_out0, reg_out1, reg_out2, reg_out3;
  logic       reg_val;
  logic [7:0] cap_cnt;

  typedef struct {
    logic [15:0] w;      // expected combinational word
    logic        rv;     // expected reg_val after the edge
    logic [15:0] rw;     // expected registered word after the edge
    logic [7:0]  cnt;    // expected cap_cnt after the edge
  } exp_t;

  exp_t        exp_q[$];
  int          n_pass = 0;
  int          n_total = 0;
  logic        armed = 1'b0;
  logic [15:0] hold_w = 16'h0000;
  logic [7:0]  exp_cnt = 8'h00;

  wire_pack_5x3_to_4x4 dut (
    .clk(clk), .reset(reset),
    .in0(in0), .in1(in1), .in2(in2), .in3(in3), .in4(in4),
    .in_val(in_val),
    .out0(out0), .out1(out1), .out2(out2), .out3(out3),
    .reg_out0(reg_out0), .reg_out1(reg_out1), .reg_out2(reg_out2), .reg_out3(reg_out3),
    .reg_val(reg_val), .cap_cnt(cap_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [15:0] pack(input logic [2:0] a, b, c, d, e);
    return {1'b1, e, d, c, b, a};
  endfunction

  // Drives one cycle of stimulus at the falling edge and queues what the next rising edge must show.
  task automatic drive(input logic [2:0] a, b, c, d, e, input logic v, input logic [15:0] w_exp);
    exp_t ent;
    logic cap;
    @(negedge clk);
    in0 = a; in1 = b; in2 = c; in3 = d; in4 = e; in_val = v;
`ifdef WIRE_PACK_REG_OUT_EN
    cap = v & armed;
`else
    cap = 1'b0;
`endif
    if (cap) begin
      hold_w  = w_exp;
      exp_cnt = exp_cnt + 8'd1;
    end
    ent.w = w_exp; ent.rv = cap; ent.rw = hold_w; ent.cnt = exp_cnt;
    exp_q.push_back(ent);
    armed = 1'b1;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_reg_out0"}, {28'h0, reg_out0}, 32'h0);
    check({tag, "_reg_out1"}, {28'h0, reg_out1}, 32'h0);
    check({tag, "_reg_out2"}, {28'h0, reg_out2}, 32'h0);
    check({tag, "_reg_out3"}, {28'h0, reg_out3}, 32'h0);
    check({tag, "_reg_val"},  {31'h0, reg_val},  32'h0);
    check({tag, "_cap_cnt"},  {24'h0, cap_cnt},  32'h0);
  endtask

  // Asserts reset between clock edges, checks the immediate clear, then releases mid-cycle.
  task automatic async_reset(input string tag);
    @(posedge clk);
    #3;
    reset = 1'b0;
    in_val = 1'b0;
    #1;
    check_cleared(tag);
    repeat (2) @(posedge clk);
    #2;
    reset   = 1'b1;
    armed   = 1'b0;
    hold_w  = 16'h0000;
    exp_cnt = 8'h00;
  endtask

  // Monitor: compares every output against the queued expectation after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("out0", {28'h0, out0}, {28'h0, e.w[3:0]});
        check("out1", {28'h0, out1}, {28'h0, e.w[7:4]});
        check("out2", {28'h0, out2}, {28'h0, e.w[11:8]});
        check("out3", {28'h0, out3}, {28'h0, e.w[15:12]});
        check("reg_val", {31'h0, reg_val}, {31'h0, e.rv});
        check("reg_word", {16'h0, reg_out3, reg_out2, reg_out1, reg_out0}, {16'h0, e.rw});
        check("cap_cnt", {24'h0, cap_cnt}, {24'h0, e.cnt});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0;
    in0 = 3'd0; in1 = 3'd0; in2 = 3'd0; in3 = 3'd0; in4 = 3'd0; in_val = 1'b0;
    #1;
    check_cleared("reset");
    check("reset_out3", {28'h0, out3}, 32'h8);
    check("reset_out0", {28'h0, out0}, 32'h0);

    @(posedge clk);
    #2;
    reset = 1'b1;

    // in_val on the release edge must be ignored.
    drive(3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 1'b1, 16'hD8D1);
    drive(3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 1'b1, 16'hD8D1);
    drive(3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0, 16'h8000);
    drive(3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 1'b0, 16'h9249);
    drive(3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 1'b1, 16'h9000);
    drive(3'd0, 3'd0, 3'd0, 3'd1, 3'd0, 1'b1, 16'h8200);
    drive(3'd0, 3'd0, 3'd1, 3'd0, 3'd0, 1'b0, 16'h8040);
    drive(3'd0, 3'd1, 3'd0, 3'd0, 3'd0, 1'b1, 16'h8008);
    drive(3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0, 16'h8001);
    drive(3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 1'b1, 16'hFD63);
    drive(3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 1'b1, 16'hFD63);

    // Reset asserted in the middle of a back-to-back burst.
    drive(3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 1'b1, 16'hD8D1);
    async_reset("midburst");

    // 256 captures after reset wrap the counter back to zero.
    drive(3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0, 16'h8000);
    for (int i = 0; i < 256; i++) begin
      logic [2:0] a, b;
      a = 3'(i);
      b = 3'(i >> 3);
      drive(a, b, 3'd0, 3'd0, 3'd7, 1'b1, pack(a, b, 3'd0, 3'd0, 3'd7));
    end
    @(posedge clk);
    #2;
`ifdef WIRE_PACK_REG_OUT_EN
    check("wrap_cap_cnt", {24'h0, cap_cnt}, 32'h0);
    check("wrap_reg_val", {31'h0, reg_val}, 32'h1);
`else
    check("noreg_cap_cnt", {24'h0, cap_cnt}, 32'h0);
    check("noreg_reg_val", {31'h0, reg_val}, 32'h0);
`endif

    for (int i = 0; i < 20; i++) begin
      logic [2:0] a, b, c, d, e;
      logic       v;
      a = 3'($urandom); b = 3'($urandom); c = 3'($urandom);
      d = 3'($urandom); e = 3'($urandom); v = 1'($urandom);
      drive(a, b, c, d, e, v, pack(a, b, c, d, e));
    end

    @(posedge clk);
    #3;
    check("queue_drained", exp_q.size(), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
